// File: rtl/pck_injct_scheduler_pkg.sv
// Scheduler-local definitions: FSM state encoding, visible to the bench.
package pck_injct_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_ISSUE,
        ST_GAP
    } sched_st_t;

endpackage

// File: rtl/pronoc_pkg.sv
// Shared NoC types: the packet-injector control interface and the field widths it uses.
package pronoc_pkg;

    localparam int V        = 2;
    localparam int Vw       = 1;
    localparam int EAw      = 4;
    localparam int Cw       = 2;
    localparam int PCK_SIZw = 6;
    localparam int DAw      = 16;
    localparam int WEIGHTw  = 4;

    typedef struct packed {
        logic [DAw-1:0]      data;
        logic [PCK_SIZw-1:0] size;
        logic [EAw-1:0]      endp_addr;
        logic [Cw-1:0]       class_num;
        logic [WEIGHTw-1:0]  init_weight;
        logic [V-1:0]        vc;
        logic                pck_wr;
    } pck_injct_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational cyclic priority search: first set request at or after the pointer.
module rr_pick #(
    parameter int NREQ = 4,
    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PTRW-1:0] i_ptr,
    output logic [PTRW-1:0] o_win,
    output logic            o_vld
);

    int w_idx;

    // Walk from the farthest offset down so the nearest hit is written last.
    always_comb begin
        o_win = '0;
        o_vld = 1'b0;
        w_idx = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_idx = (int'(i_ptr) + i) % NREQ;
            if (i_req[w_idx[PTRW-1:0]]) begin
                o_win = w_idx[PTRW-1:0];
                o_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pck_injct_scheduler.sv
// Round-robin arbiter of NREQ local requesters onto one packet-injector command port,
// with a ready wait, a one-cycle registered pck_wr/grant pulse and an enforced idle gap.
module pck_injct_scheduler
    import pronoc_pkg::*;
    import pck_injct_scheduler_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MIN_GAP  = 0,
    parameter int MIN_SIZE = 2,
    parameter int MAX_SIZE = 31
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*EAw-1:0]      req_dest,
    input  logic [NREQ*PCK_SIZw-1:0] req_size,
    input  logic [NREQ*Vw-1:0]       req_vc,
    input  logic [NREQ*Cw-1:0]       req_class,
    input  logic [NREQ*DAw-1:0]      req_data,
    input  logic [V-1:0]             inj_ready,
    output pck_injct_t               inj_cmd,
    output logic [NREQ-1:0]          grant_ack,
    output logic                     busy,
    output logic [31:0]              pck_cnt
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_st_t       r_state;
    sched_st_t       w_next;
    logic [PTRW-1:0] r_ptr;
    logic [PTRW-1:0] r_win;
    pck_injct_t      r_cmd;
    logic            r_pck_wr;
    logic [NREQ-1:0] r_ack;
    logic [7:0]      r_gap;
    logic [31:0]     r_cnt;
    logic [PTRW-1:0] w_win;
    logic            w_vld;

    function automatic logic [PCK_SIZw-1:0] clamp_size(input logic [PCK_SIZw-1:0] s);
        if (s < PCK_SIZw'(MIN_SIZE)) return PCK_SIZw'(MIN_SIZE);
        if (s > PCK_SIZw'(MAX_SIZE)) return PCK_SIZw'(MAX_SIZE);
        return s;
    endfunction

    // Out-of-range VC indexes fall back to VC 0.
    function automatic logic [V-1:0] vc_onehot(input logic [Vw-1:0] idx);
        logic [V-1:0] oh;
        oh = '0;
        for (int k = 0; k < V; k++) begin
            if (idx == Vw'(k)) oh[k] = 1'b1;
        end
        if (oh == '0) oh[0] = 1'b1;
        return oh;
    endfunction

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_win (w_win),
        .o_vld (w_vld)
    );

    always_comb begin
        w_next         = r_state;
        busy           = (r_state != ST_IDLE);
        inj_cmd        = r_cmd;
        inj_cmd.pck_wr = r_pck_wr;
        case (r_state)
            ST_IDLE:     if (w_vld) w_next = ST_WAIT_RDY;
            ST_WAIT_RDY: begin
                if (!req[r_win])                 w_next = ST_IDLE;
                else if (|(inj_ready & r_cmd.vc)) w_next = ST_ISSUE;
            end
            ST_ISSUE:    w_next = (MIN_GAP > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:      if (r_gap <= 8'd1) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // The write pulse, ack, count and pointer all update on the edge leaving ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= ST_IDLE;
            r_ptr             <= '0;
            r_win             <= '0;
            r_cmd             <= '0;
            r_cmd.init_weight <= WEIGHTw'(1);
            r_pck_wr          <= 1'b0;
            r_ack             <= '0;
            r_gap             <= '0;
            r_cnt             <= '0;
        end else begin
            r_state  <= w_next;
            r_pck_wr <= (r_state == ST_ISSUE);
            r_ack    <= '0;
            case (r_state)
                ST_IDLE: if (w_vld) begin
                    r_win           <= w_win;
                    r_cmd.endp_addr <= req_dest[int'(w_win)*EAw +: EAw];
                    r_cmd.size      <= clamp_size(req_size[int'(w_win)*PCK_SIZw +: PCK_SIZw]);
                    r_cmd.vc        <= vc_onehot(req_vc[int'(w_win)*Vw +: Vw]);
                    r_cmd.class_num <= req_class[int'(w_win)*Cw +: Cw];
                    r_cmd.data      <= req_data[int'(w_win)*DAw +: DAw];
                end
                ST_ISSUE: begin
                    r_ack[r_win] <= 1'b1;
                    r_cnt        <= r_cnt + 32'd1;
                    r_ptr        <= (r_win == PTRW'(NREQ - 1)) ? '0 : r_win + 1'b1;
                    r_gap        <= 8'(MIN_GAP);
                end
                ST_GAP:  r_gap <= r_gap - 8'd1;
                default: ;
            endcase
        end
    end

    assign grant_ack = r_ack;
    assign pck_cnt   = r_cnt;

endmodule

// File: tb/tb_pck_injct_scheduler.sv
// Bench for pck_injct_scheduler: two instances (MIN_GAP 0 and 4) on shared stimulus,
// compared every cycle against a transaction-level model, plus directed spot checks.
module tb_pck_injct_scheduler;
    import pronoc_pkg::*;

    localparam int NREQ = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset = 1'b1;
    logic [NREQ-1:0]          req = '0;
    logic [NREQ*EAw-1:0]      req_dest = '0;
    logic [NREQ*PCK_SIZw-1:0] req_size = '0;
    logic [NREQ*Vw-1:0]       req_vc = '0;
    logic [NREQ*Cw-1:0]       req_class = '0;
    logic [NREQ*DAw-1:0]      req_data = '0;
    logic [V-1:0]             inj_ready = '0;

    pck_injct_t      cmd0, cmd4;
    logic [NREQ-1:0] ack0, ack4;
    logic            busy0, busy4;
    logic [31:0]     cnt0, cnt4;

    pck_injct_scheduler #(.NREQ(NREQ), .MIN_GAP(0), .MIN_SIZE(2), .MAX_SIZE(31)) u_dut0 (
        .clk(clk), .reset(reset), .req(req), .req_dest(req_dest), .req_size(req_size),
        .req_vc(req_vc), .req_class(req_class), .req_data(req_data), .inj_ready(inj_ready),
        .inj_cmd(cmd0), .grant_ack(ack0), .busy(busy0), .pck_cnt(cnt0)
    );

    pck_injct_scheduler #(.NREQ(NREQ), .MIN_GAP(4), .MIN_SIZE(2), .MAX_SIZE(31)) u_dut4 (
        .clk(clk), .reset(reset), .req(req), .req_dest(req_dest), .req_size(req_size),
        .req_vc(req_vc), .req_class(req_class), .req_data(req_data), .inj_ready(inj_ready),
        .inj_cmd(cmd4), .grant_ack(ack4), .busy(busy4), .pck_cnt(cnt4)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: owner = requester holding the port (-1 none), issue = write pending,
    // pulse = write visible this cycle, cool = remaining forced idle cycles.
    int          m_owner [2];
    int          m_vidx  [2];
    int          m_cool  [2];
    int          m_ptr   [2];
    int          m_pown  [2];
    bit          m_issue [2];
    bit          m_pulse [2];
    logic [31:0] m_cnt   [2];
    pck_injct_t  m_cmd   [2];

    function automatic int gapv(input int g);
        return (g == 0) ? 0 : 4;
    endfunction

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int k = 0; k < NREQ; k++) if (v[k]) r = k;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step();
        int s, v, c;
        for (int g = 0; g < 2; g++) begin
            if (reset) begin
                m_owner[g] = -1; m_issue[g] = 0; m_pulse[g] = 0; m_cool[g] = 0;
                m_ptr[g] = 0; m_pown[g] = 0; m_vidx[g] = 0; m_cnt[g] = '0;
                m_cmd[g] = '0;
                m_cmd[g].init_weight = WEIGHTw'(1);
            end else begin
                m_pulse[g] = m_issue[g];
                if (m_issue[g]) begin
                    m_pown[g]  = m_owner[g];
                    m_cnt[g]   = m_cnt[g] + 32'd1;
                    m_ptr[g]   = (m_owner[g] + 1) % NREQ;
                    m_owner[g] = -1;
                    m_issue[g] = 0;
                    m_cool[g]  = gapv(g);
                end else if (m_cool[g] > 0) begin
                    m_cool[g] = m_cool[g] - 1;
                end else if (m_owner[g] >= 0) begin
                    if (req[m_owner[g]] == 1'b0) m_owner[g] = -1;
                    else if (inj_ready[m_vidx[g]] == 1'b1) m_issue[g] = 1;
                end else begin
                    for (int o = 0; o < NREQ; o++) begin
                        c = (m_ptr[g] + o) % NREQ;
                        if (req[c] == 1'b1 && m_owner[g] < 0) begin
                            m_owner[g] = c;
                            s = int'(req_size[c*PCK_SIZw +: PCK_SIZw]);
                            if (s < 2) s = 2;
                            if (s > 31) s = 31;
                            v = int'(req_vc[c*Vw +: Vw]);
                            if (v >= V) v = 0;
                            m_vidx[g] = v;
                            m_cmd[g].size      = PCK_SIZw'(s);
                            m_cmd[g].vc        = V'(1 << v);
                            m_cmd[g].endp_addr = req_dest[c*EAw +: EAw];
                            m_cmd[g].class_num = req_class[c*Cw +: Cw];
                            m_cmd[g].data      = req_data[c*DAw +: DAw];
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        pck_injct_t      e_cmd;
        logic [NREQ-1:0] e_ack;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        for (int g = 0; g < 2; g++) begin
            e_cmd        = m_cmd[g];
            e_cmd.pck_wr = m_pulse[g];
            e_ack        = m_pulse[g] ? NREQ'(1 << m_pown[g]) : '0;
            chk($sformatf("cmd_g%0d", g),  64'(g == 0 ? cmd0 : cmd4), 64'(e_cmd));
            chk($sformatf("ack_g%0d", g),  64'(g == 0 ? ack0 : ack4), 64'(e_ack));
            chk($sformatf("busy_g%0d", g), 64'(g == 0 ? busy0 : busy4),
                64'((m_owner[g] >= 0) || (m_cool[g] > 0)));
            chk($sformatf("cnt_g%0d", g),  64'(g == 0 ? cnt0 : cnt4), 64'(m_cnt[g]));
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        req   = '0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [EAw-1:0] d, input logic [PCK_SIZw-1:0] s,
                           input logic [Vw-1:0] v, input logic [Cw-1:0] c, input logic [DAw-1:0] dt);
        req_dest[i*EAw +: EAw]           = d;
        req_size[i*PCK_SIZw +: PCK_SIZw] = s;
        req_vc[i*Vw +: Vw]               = v;
        req_class[i*Cw +: Cw]            = c;
        req_data[i*DAw +: DAw]           = dt;
    endtask

    task automatic wait_pulse(input int max_t, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (cmd0.pck_wr !== 1'b1 && n < max_t);
    endtask

    initial begin
        int n, pulses;
        int order[$];
        int t0[$];
        int t4[$];
        int sizes[$];
        pck_injct_t z;

        // Idle after reset
        do_reset(3);
        repeat (20) tick();
        chk("idle_cnt", 64'(cnt0), 64'd0);
        chk("idle_busy", 64'(busy0), 64'd0);
        chk("idle_wr", 64'(cmd0.pck_wr), 64'd0);

        // Single request on VC 1
        set_req(1, 4'h3, 6'd5, 1'b1, 2'd2, 16'hBEEF);
        inj_ready = 2'b11;
        req = 4'b0010;
        wait_pulse(8, n);
        chk("single_lat", 64'(n), 64'd3);
        chk("single_ack", 64'(ack0), 64'b0010);
        chk("single_vc", 64'(cmd0.vc), 64'b10);
        chk("single_size", 64'(cmd0.size), 64'd5);
        chk("single_cnt", 64'(cnt0), 64'd1);
        req = '0;
        repeat (8) tick();

        // All four requesting, each drops after its ack
        do_reset(2);
        for (int i = 0; i < NREQ; i++)
            set_req(i, EAw'(i + 8), PCK_SIZw'(4 + i), Vw'(i % 2), Cw'(i), DAw'(16'h1000 + i));
        req = 4'b1111;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (cmd0.pck_wr === 1'b1) begin
                order.push_back(oh_idx(ack0));
                t0.push_back(cyc);
            end
            if (m_pulse[0]) req[m_pown[0]] = 1'b0;
        end
        chk("rr_n", 64'(order.size()), 64'd4);
        for (int i = 0; i < order.size(); i++) chk("rr_order", 64'(order[i]), 64'(i));
        for (int i = 1; i < t0.size(); i++) chk("rr_space", 64'(t0[i] - t0[i-1]), 64'd3);

        // Hold in WAIT_RDY until VC 0 becomes ready
        do_reset(2);
        set_req(0, 4'h5, 6'd7, 1'b0, 2'd1, 16'h00AA);
        inj_ready = 2'b10;
        req = 4'b0001;
        pulses = 0;
        repeat (10) begin
            tick();
            if (cmd0.pck_wr === 1'b1) pulses++;
        end
        chk("rdy_nopulse", 64'(pulses), 64'd0);
        chk("rdy_busy", 64'(busy0), 64'd1);
        inj_ready = 2'b11;
        wait_pulse(6, n);
        chk("rdy_lat", 64'(n), 64'd2);
        req = '0;
        repeat (8) tick();

        // Winner withdraws during WAIT_RDY; pointer must not move
        do_reset(2);
        set_req(1, 4'h1, 6'd3, 1'b0, 2'd0, 16'h0011);
        inj_ready = 2'b11;
        req = 4'b0010;
        wait_pulse(8, n);
        chk("cx_first", 64'(ack0), 64'b0010);
        req = '0;
        repeat (6) tick();
        set_req(2, 4'h2, 6'd9, 1'b1, 2'd3, 16'h0022);
        set_req(0, 4'h7, 6'd4, 1'b0, 2'd1, 16'h0033);
        inj_ready = 2'b00;
        req = 4'b0100;
        tick();
        tick();
        chk("cx_wait", 64'(busy0), 64'd1);
        req = '0;
        pulses = 0;
        repeat (2) begin
            tick();
            if (cmd0.pck_wr === 1'b1) pulses++;
        end
        chk("cx_nopulse", 64'(pulses), 64'd0);
        chk("cx_idle", 64'(busy0), 64'd0);
        inj_ready = 2'b11;
        req = 4'b0111;
        wait_pulse(8, n);
        chk("cx_lat", 64'(n), 64'd3);
        chk("cx_same", 64'(ack0), 64'b0100);
        req = '0;
        repeat (8) tick();

        // Size clamping
        do_reset(2);
        set_req(0, 4'h4, 6'd1, 1'b0, 2'd0, 16'h0101);
        set_req(1, 4'h6, 6'd40, 1'b1, 2'd1, 16'h0202);
        inj_ready = 2'b11;
        req = 4'b0011;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (cmd0.pck_wr === 1'b1) sizes.push_back(int'(cmd0.size));
            if (m_pulse[0]) req[m_pown[0]] = 1'b0;
        end
        chk("sz_n", 64'(sizes.size()), 64'd2);
        if (sizes.size() == 2) begin
            chk("sz_min", 64'(sizes[0]), 64'd2);
            chk("sz_max", 64'(sizes[1]), 64'd31);
        end

        // Saturated load: spacing 3 without gap, 7 with MIN_GAP=4
        do_reset(2);
        t0.delete();
        req = 4'b1111;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (cmd0.pck_wr === 1'b1) t0.push_back(cyc);
            if (cmd4.pck_wr === 1'b1) t4.push_back(cyc);
        end
        chk("sat_n0", 64'(t0.size() >= 10), 64'd1);
        chk("sat_n4", 64'(t4.size() >= 4), 64'd1);
        for (int i = 1; i < t0.size(); i++) chk("sat_sp0", 64'(t0[i] - t0[i-1]), 64'd3);
        for (int i = 1; i < t4.size(); i++) chk("sat_sp4", 64'(t4[i] - t4[i-1]), 64'd7);

        // Reset while waiting for ready, request still asserted
        req = '0;
        repeat (10) tick();
        inj_ready = 2'b00;
        set_req(0, 4'hF, 6'd12, 1'b1, 2'd3, 16'hFFFF);
        req = 4'b0001;
        tick();
        tick();
        chk("rst_pre_busy", 64'(busy0), 64'd1);
        reset = 1'b1;
        tick();
        z = '0;
        z.init_weight = WEIGHTw'(1);
        chk("rst_cmd", 64'(cmd0), 64'(z));
        chk("rst_ack", 64'(ack0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_cnt", 64'(cnt0), 64'd0);
        reset = 1'b0;
        req = '0;
        repeat (4) tick();

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] == 1'b0 && ($urandom % 4) == 0) begin
                    set_req(i, EAw'($urandom), PCK_SIZw'($urandom), Vw'($urandom),
                            Cw'($urandom), DAw'($urandom));
                    req[i] = 1'b1;
                end else if (req[i] == 1'b1 && ($urandom % 40) == 0) begin
                    req[i] = 1'b0;
                end
            end
            inj_ready = V'($urandom);
            reset = (($urandom % 200) == 0);
            tick();
            if (m_pulse[0]) req[m_pown[0]] = 1'b0;
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pck_injct_scheduler.md
Name: pck_injct_scheduler

Overview:
- Arbitrates NREQ local traffic requesters onto the single pck_injct_t control interface of one endpoint's packet injector.
- Sits between on-tile traffic sources (test generators, DMA, processor bridge) and the injector.
- Round-robin selection; waits for the chosen VC's ready bit; issues a one-cycle pck_wr; acknowledges the winner.
- Enforces a programmable minimum idle gap between injections and counts injected packets.

Parameters:
NREQ, 4, number of requesters (2..16)
MIN_GAP, 0, idle cycles forced after every pck_wr (0..255)
MIN_SIZE, 2, smallest legal packet size in flits; smaller requests are raised to it
MAX_SIZE, 31, largest legal size; larger requests are clamped to it

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  NREQ  per-requester injection request; level, held until grant_ack
req_dest  input  NREQ*EAw  destination endpoint address per requester
req_size  input  NREQ*PCK_SIZw  packet size in flits per requester
req_vc  input  NREQ*Vw  VC index per requester
req_class  input  NREQ*Cw  message class per requester
req_data  input  NREQ*DAw  header payload data per requester
inj_ready  input  V  per-VC ready from the injector (pck_injct_out.ready)
inj_cmd  output  pck_injct_t  command to the injector (pck_injct_in)
grant_ack  output  NREQ  one-hot, one-cycle pulse in the cycle inj_cmd.pck_wr is high
busy  output  1  high in every state except IDLE
pck_cnt  output  32  packets issued since reset; wraps 0xFFFFFFFF -> 0

Behaviour:
- Reset (clock-synchronous, active-high): state=IDLE; RR pointer=0; all inj_cmd fields=0 with pck_wr=0 and init_weight=1; grant_ack=0; busy=0; pck_cnt=0; gap counter=0. A reset asserted mid-operation aborts any latched request without issuing pck_wr.
- FSM states: IDLE, WAIT_RDY, ISSUE, GAP.
- IDLE: if any req bit is set, pick the first set bit at or after the RR pointer (cyclic search).
  - Latch the winner index and its dest, size, vc, class and data into the inj_cmd registers.
  - Go to WAIT_RDY. Latching costs one cycle.
- Field conditioning at latch:
  - size = max(MIN_SIZE, min(MAX_SIZE, req_size)).
  - vc index >= V maps to VC 0.
  - inj_cmd.vc is one-hot of the resulting index.
- WAIT_RDY:
  - If req[winner] is low: cancel and return to IDLE. No ack; pointer unchanged.
  - Else if inj_ready[vc] is high: go to ISSUE.
  - Otherwise hold indefinitely.
- ISSUE (exactly one cycle):
  - inj_cmd.pck_wr=1, grant_ack[winner]=1, pck_cnt+=1.
  - RR pointer = winner+1, wrapping to 0 at NREQ.
  - Next state: GAP if MIN_GAP>0, else IDLE.
- GAP: counter loads MIN_GAP on entry and decrements each cycle; return to IDLE when it reaches 1. No arbitration occurs in GAP.
- Latency: req sampled in IDLE at edge t, ready already high → pck_wr high in the cycle after edge t+2. Best-case throughput is one packet per 3+MIN_GAP cycles.
- pck_wr never asserts on two consecutive cycles. inj_cmd fields stay stable from WAIT_RDY through ISSUE.
- Requesters whose req bit changes during WAIT_RDY/ISSUE/GAP, other than the winner, have no effect until the next IDLE.
- Simultaneous req and reset: reset wins.

Decomposition:
- Shared package (pronoc_pkg) already provides pck_injct_t, EAw, V, Vw, Cw, PCK_SIZw and DAw; no new typedefs.
- Add the FSM state enum sched_st_t to the package for bench visibility.
- Sub-module rr_pick: combinational NREQ-wide cyclic priority search; inputs req and pointer; outputs winner index and a valid flag.

Test Plan:
- Reset release, no req for 20 cycles → pck_wr=0, busy=0, pck_cnt=0 throughout.
- req=4'b0010, size=5, vc=1, inj_ready=2'b11 → pck_wr 3 cycles after req seen; grant_ack=4'b0010; inj_cmd.vc=2'b10; size=5; pck_cnt=1.
- req=4'b1111 held (each dropped after its ack), MIN_GAP=0, ready high → grants in order 0,1,2,3; pck_wr pulses exactly 3 cycles apart.
- req[0] with vc=0 and inj_ready[0]=0 for 10 cycles, then 1 → busy high, no pck_wr until ready; pck_wr one ISSUE cycle after ready rises.
- Winner drops req during WAIT_RDY → no pck_wr, no ack, return to IDLE; the next grant goes to the same index if it re-requests.
- size=1 and size=40 requests → issued sizes 2 and 31. MIN_GAP=4 → 7 cycles between pck_wr pulses. Reset during WAIT_RDY → no pulse; all outputs return to 0 values.
